// File: rtl/sr_cmd_driver_if.sv
// Command handshake between control logic and the SR flip-flop driver.
// The master is the command source; the slave is sr_cmd_driver.
interface sr_cmd_driver_if;
    logic cmd_valid;
    logic cmd_set;
    logic cmd_ready;

    modport master (output cmd_valid, output cmd_set, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_set, output cmd_ready);
endinterface

// File: rtl/sr_cmd_driver.sv
// Turns queued set/clear commands into mutually exclusive S/R pulses for an SR
// flip-flop, then confirms Q feedback and reports done or a timeout error.
module sr_cmd_driver #(
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned GAP_CYCLES   = 1,
    parameter int unsigned TIMEOUT      = 8,
    parameter int unsigned DEPTH        = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    sr_cmd_driver_if.slave    cmd,
    output logic              S,
    output logic              R,
    input  logic              q_fb,
    output logic              done,
    output logic              err,
    output logic              busy
);

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NW      = $clog2(DEPTH + 1);
    localparam int unsigned CMAX_PG = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned CMAX    = (CMAX_PG > TIMEOUT) ? CMAX_PG : TIMEOUT;
    localparam int unsigned CW      = $clog2(CMAX + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_CHECK = 2'd3;

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [NW-1:0]    count;
    logic [NW-1:0]    count_n;
    logic             full_c;
    logic             push_c;
    logic             pop_c;

    logic [1:0]       state;
    logic [1:0]       state_n;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic             target;
    logic             target_n;
    logic             done_n;
    logic             err_n;
    logic             s_n;
    logic             r_n;
    logic             busy_n;

    // Command FIFO: ready is purely a function of the occupancy register.
    assign full_c        = (count == NW'(DEPTH));
    assign cmd.cmd_ready = !full_c;
    assign push_c        = cmd.cmd_valid && !full_c;
    assign pop_c         = (state == ST_IDLE) && (count != '0);

    always_comb begin
        count_n = count;
        case ({push_c, pop_c})
            2'b10:   count_n = count + NW'(1);
            2'b01:   count_n = count - NW'(1);
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= cmd.cmd_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_n;
        end
    end

    // Next-state logic; each phase counter is reloaded on state entry.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        target_n = target;
        done_n   = 1'b0;
        err_n    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pop_c) begin
                    target_n = mem[rd_ptr];
                    cnt_n    = CW'(PULSE_CYCLES - 1);
                    state_n  = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt == '0) begin
                    cnt_n   = CW'(GAP_CYCLES - 1);
                    state_n = ST_GAP;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    cnt_n   = CW'(TIMEOUT - 1);
                    state_n = ST_CHECK;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ST_CHECK: begin
                if (q_fb == target) begin
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end else if (cnt == '0) begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        // S and R derive from one decoded state, so they can never overlap.
        s_n    = (state_n == ST_DRIVE) && target_n;
        r_n    = (state_n == ST_DRIVE) && !target_n;
        busy_n = (state_n != ST_IDLE) || (count_n != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            target <= 1'b0;
            S      <= 1'b0;
            R      <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            target <= target_n;
            S      <= s_n;
            R      <= r_n;
            done   <= done_n;
            err    <= err_n;
            busy   <= busy_n;
        end
    end

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Scoreboard bench for sr_cmd_driver: directed timing checks plus a queue of
// expected outcomes and pulse directions compared as the DUT produces them.
module tb_sr_cmd_driver;

    typedef struct packed {
        logic set;
        logic done;
    } exp_t;

    logic clk;
    logic rst_n;
    logic S;
    logic R;
    logic q_fb;
    logic done;
    logic err;
    logic busy;

    logic q_mod;
    logic stuck_en;
    logic stuck_val;

    int   n_checks;
    int   n_errors;
    int   done_cnt;
    int   err_cnt;

    exp_t sb_q[$];
    logic pulse_q[$];
    logic prev_sr;
    logic mon_e;
    exp_t mon_x;

    logic [15:0] m_s;
    logic [15:0] m_r;
    logic [15:0] m_d;
    logic [15:0] m_e;
    logic [15:0] m_b;
    logic [5:0]  pat;
    logic        seen;

    sr_cmd_driver_if cmd_if ();

    sr_cmd_driver dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cmd   (cmd_if.slave),
        .S     (S),
        .R     (R),
        .q_fb  (q_fb),
        .done  (done),
        .err   (err),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SR flip-flop model, or a stuck Q when stuck_en is set.
    always @(posedge clk) begin
        if (S)      q_mod <= 1'b1;
        else if (R) q_mod <= 1'b0;
    end
    assign q_fb = stuck_en ? stuck_val : q_mod;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic record(input logic set);
        exp_t x;
        x.set  = set;
        x.done = stuck_en ? (stuck_val == set) : 1'b1;
        sb_q.push_back(x);
        pulse_q.push_back(set);
    endtask

    task automatic push_cmd(input logic set);
        bit acc;
        acc = 1'b0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_set   = set;
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clk);
            acc = cmd_if.cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_if.cmd_valid = 1'b0;
        if (acc) record(set);
        else     check_eq("push_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int max_cyc);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < max_cyc && !idle; i++) begin
            @(negedge clk);
            idle = !busy;
        end
        @(posedge clk);
        #1;
        if (!idle) check_eq("idle_timeout", 0, 1);
    endtask

    // Output monitor: exclusivity, pulse order, and done/err outcome scoreboard.
    always @(negedge clk) begin
        check_eq("s_r_excl", 32'(S & R), 0);
        if (rst_n) begin
            check_eq("done_err_excl", 32'(done & err), 0);
            if ((S || R) && !prev_sr) begin
                if (pulse_q.size() == 0) begin
                    check_eq("pulse_unexpected", 1, 0);
                end else begin
                    mon_e = pulse_q.pop_front();
                    check_eq("pulse_dir", 32'(S), 32'(mon_e));
                end
            end
            if (done || err) begin
                if (done) done_cnt++;
                if (err)  err_cnt++;
                if (sb_q.size() == 0) begin
                    check_eq("sb_unexpected", 1, 0);
                end else begin
                    mon_x = sb_q.pop_front();
                    check_eq("sb_done", 32'(done), 32'(mon_x.done));
                    check_eq("sb_err", 32'(err), 32'(!mon_x.done));
                    if (done) check_eq("sb_q_fb", 32'(q_fb), 32'(mon_x.set));
                end
            end
        end
        prev_sr = S || R;
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        done_cnt = 0;
        err_cnt  = 0;
        prev_sr  = 1'b0;
        q_mod    = 1'b0;
        stuck_en = 1'b0;
        stuck_val = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_set   = 1'b0;
        rst_n = 1'b1;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_S", 32'(S), 0);
        check_eq("rst_R", 32'(R), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_err", 32'(err), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_ready", 32'(cmd_if.cmd_ready), 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single set, closed loop: pulse 2-3, gap 4, check 5, done 6
        m_s = 16'h000C;
        m_d = 16'h0040;
        m_b = 16'h003E;
        push_cmd(1'b1);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            check_eq("t2_S", 32'(S), 32'(m_s[c]));
            check_eq("t2_R", 32'(R), 0);
            check_eq("t2_done", 32'(done), 32'(m_d[c]));
            check_eq("t2_busy", 32'(busy), 32'(m_b[c]));
        end
        wait_idle(50);

        // Clear with Q stuck high: 8 check cycles then err at 13
        stuck_en  = 1'b1;
        stuck_val = 1'b1;
        m_r = 16'h000C;
        m_e = 16'h2000;
        push_cmd(1'b0);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            check_eq("t3_R", 32'(R), 32'(m_r[c]));
            check_eq("t3_S", 32'(S), 0);
            check_eq("t3_err", 32'(err), 32'(m_e[c]));
            check_eq("t3_done", 32'(done), 0);
        end
        wait_idle(50);

        // Reset during a drive pulse with three commands still queued
        stuck_val = 1'b0;
        push_cmd(1'b1);
        push_cmd(1'b0);
        push_cmd(1'b1);
        push_cmd(1'b1);
        push_cmd(1'b0);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = S || R;
        end
        check_eq("t1_drive_seen", 32'(seen), 1);
        @(posedge clk);
        #1;
        check_eq("t1_pre_R", 32'(R), 1);
        rst_n = 1'b0;
        #1;
        check_eq("t1_S", 32'(S), 0);
        check_eq("t1_R", 32'(R), 0);
        check_eq("t1_busy", 32'(busy), 0);
        check_eq("t1_ready", 32'(cmd_if.cmd_ready), 1);
        check_eq("t1_done", 32'(done), 0);
        check_eq("t1_err", 32'(err), 0);
        sb_q.delete();
        pulse_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen = seen | S | R | done | err | busy;
        end
        check_eq("t1_quiet", 32'(seen), 0);

        // FIFO full: five accepted back-to-back, sixth stalls; order preserved
        stuck_val = 1'b1;
        pat = 6'b101001;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            cmd_if.cmd_valid = 1'b1;
            cmd_if.cmd_set   = pat[i];
            @(negedge clk);
            check_eq("t4_ready", 32'(cmd_if.cmd_ready), 1);
            @(posedge clk);
            #1;
            record(pat[i]);
        end
        cmd_if.cmd_set = pat[5];
        @(negedge clk);
        check_eq("t4_full", 32'(cmd_if.cmd_ready), 0);
        @(posedge clk);
        #1;
        push_cmd(pat[5]);
        wait_idle(400);
        check_eq("t4_sb_drained", 32'(sb_q.size()), 0);
        check_eq("t4_pulses_drained", 32'(pulse_q.size()), 0);

        // Closed loop, alternating set/clear four times
        stuck_en = 1'b0;
        done_cnt = 0;
        err_cnt  = 0;
        for (int i = 0; i < 4; i++) begin
            push_cmd((i % 2) == 0);
        end
        wait_idle(200);
        check_eq("t5_done_cnt", 32'(done_cnt), 4);
        check_eq("t5_err_cnt", 32'(err_cnt), 0);
        check_eq("t5_q_final", 32'(q_fb), 0);

        // New command pushed in the done cycle is popped the next cycle
        done_cnt = 0;
        push_cmd(1'b1);
        repeat (5) @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_set   = 1'b0;
        @(negedge clk);
        check_eq("t6_done_same", 32'(done), 1);
        check_eq("t6_ready", 32'(cmd_if.cmd_ready), 1);
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        record(1'b0);
        @(negedge clk);
        check_eq("t6_R_pop", 32'(R), 0);
        check_eq("t6_busy", 32'(busy), 1);
        @(negedge clk);
        check_eq("t6_R_start", 32'(R), 1);
        wait_idle(100);
        check_eq("t6_done_cnt", 32'(done_cnt), 2);
        check_eq("final_sb_empty", 32'(sb_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
